instruction_fetch: RTL and testbench

Fetch stage of the single-issue MIPS-style core. Owns the program counter, drives the byte address into the combinational, byte-addressed, big-endian instruction memory, and captures the returned 32-bit word into the IF/ID pipeline register. Resolves unconditional jumps (opcode 000010) locally. Accepts branch redirects from the execute stage, honours pipeline stalls, and stops fetching on the end-of-program word.

---
 rtl/instruction_fetch_if.sv | 27 ++
 rtl/instruction_fetch.sv | 60 ++++++
 tb/tb_instruction_fetch.sv | 128 ++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - fetch stage bus: imem port, hazard/redirect inputs, IF/ID outputs
interface instruction_fetch_if #(
    parameter int N = 32
);
    logic         stall;
    logic         branch_taken;
    logic [N-1:0] branch_target;
    logic [N-1:0] imem_address;
    logic [N-1:0] imem_instruction;
    logic [N-1:0] if_id_instruction;
    logic [N-1:0] if_id_pc_plus4;
    logic         if_id_valid;
    logic         halted;
    logic [15:0]  fetch_count;

    modport master (
        input  stall, branch_taken, branch_target, imem_instruction,
        output imem_address, if_id_instruction, if_id_pc_plus4, if_id_valid,
               halted, fetch_count
    );

    modport slave (
        output stall, branch_taken, branch_target, imem_instruction,
        input  imem_address, if_id_instruction, if_id_pc_plus4, if_id_valid,
               halted, fetch_count
    );
endinterface

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC, local jump resolution, redirect/stall/halt handling, IF/ID register
module instruction_fetch #(
    parameter int           N         = 32,
    parameter logic [N-1:0] RESET_PC  = '0,
    parameter logic [N-1:0] HALT_WORD = 32'h0000_0021
) (
    input  logic              clk,
    input  logic              rst,
    instruction_fetch_if.master bus
);
    typedef enum logic {RUN, HALTED} state_t;

    state_t       state;
    logic [N-1:0] pc;
    logic [N-1:0] pc_plus4;
    logic         is_jump;

    assign pc_plus4         = pc + N'(4);
    assign is_jump          = (bus.imem_instruction[N-1:N-6] == 6'b000010);
    assign bus.imem_address = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= RUN;
            pc                    <= RESET_PC;
            bus.if_id_instruction <= '0;
            bus.if_id_pc_plus4    <= '0;
            bus.if_id_valid       <= 1'b0;
            bus.halted            <= 1'b0;
            bus.fetch_count       <= '0;
        end else if (bus.branch_taken) begin
            // Redirect beats stall: the wrong-path word in IF/ID is discarded.
            pc              <= {bus.branch_target[N-1:2], 2'b00};
            bus.if_id_valid <= 1'b0;
            state           <= RUN;
            bus.halted      <= 1'b0;
        end else if (bus.stall) begin
            pc <= pc;
        end else if (state == HALTED) begin
            bus.if_id_valid <= 1'b0;
        end else if (is_jump) begin
            // Jump consumed here; it never reaches decode.
            pc              <= {pc_plus4[N-1:28], bus.imem_instruction[25:0], 2'b00};
            bus.if_id_valid <= 1'b0;
        end else if (bus.imem_instruction == HALT_WORD) begin
            bus.if_id_instruction <= bus.imem_instruction;
            bus.if_id_pc_plus4    <= pc_plus4;
            bus.if_id_valid       <= 1'b1;
            bus.fetch_count       <= bus.fetch_count + 16'd1;
            state                 <= HALTED;
            bus.halted            <= 1'b1;
        end else begin
            bus.if_id_instruction <= bus.imem_instruction;
            bus.if_id_pc_plus4    <= pc_plus4;
            bus.if_id_valid       <= 1'b1;
            bus.fetch_count       <= bus.fetch_count + 16'd1;
            pc                    <= pc_plus4;
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed vector bench for instruction_fetch
module tb_instruction_fetch;
    logic clk = 1'b0;
    logic rst = 1'b1;

    instruction_fetch_if #(.N(32)) bus ();

    instruction_fetch #(.N(32), .RESET_PC(32'h0), .HALT_WORD(32'h0000_0021)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory: word at A is A0000000|A[9:0], except a jump at 16 and HALT at 84.
    always_comb begin
        if (bus.imem_address == 32'd16)
            bus.imem_instruction = 32'h0800_0006;
        else if (bus.imem_address == 32'd84)
            bus.imem_instruction = 32'h0000_0021;
        else
            bus.imem_instruction = {22'h28_0000, bus.imem_address[9:0]};
    end

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] addr;
        logic        valid;
        logic        chk;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        halted;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    function automatic vec_t mk(logic r, logic s, logic b, logic [31:0] t, logic [31:0] a,
                                logic v, logic c, logic [31:0] i, logic [31:0] p,
                                logic h, logic [15:0] n);
        vec_t x;
        x.rst = r; x.stall = s; x.br = b; x.tgt = t; x.addr = a; x.valid = v;
        x.chk = c; x.instr = i; x.pc4 = p; x.halted = h; x.cnt = n;
        return x;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(vec_t v, int idx);
        @(negedge clk);
        rst              = v.rst;
        bus.stall        = v.stall;
        bus.branch_taken = v.br;
        bus.branch_target = v.tgt;
        @(posedge clk);
        #1;
        check($sformatf("addr[%0d]", idx), bus.imem_address, v.addr);
        check($sformatf("valid[%0d]", idx), {31'd0, bus.if_id_valid}, {31'd0, v.valid});
        check($sformatf("halted[%0d]", idx), {31'd0, bus.halted}, {31'd0, v.halted});
        check($sformatf("count[%0d]", idx), {16'd0, bus.fetch_count}, {16'd0, v.cnt});
        if (v.chk) begin
            check($sformatf("instr[%0d]", idx), bus.if_id_instruction, v.instr);
            check($sformatf("pc4[%0d]", idx), bus.if_id_pc_plus4, v.pc4);
        end
    endtask

    initial begin
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_target = '0;

        //            rst s  br tgt    addr   v  chk instr          pc4 h  cnt
        vecs.push_back(mk(1, 0, 0, 0,     0,     0, 1, 32'h0,         0,  0, 0));
        vecs.push_back(mk(0, 0, 0, 0,     4,     1, 1, 32'hA000_0000, 4,  0, 1));
        vecs.push_back(mk(0, 0, 0, 0,     8,     1, 1, 32'hA000_0004, 8,  0, 2));
        vecs.push_back(mk(0, 1, 1, 22,    20,    0, 0, 0,             0,  0, 2));
        vecs.push_back(mk(0, 0, 1, 16,    16,    0, 0, 0,             0,  0, 2));
        vecs.push_back(mk(0, 0, 0, 0,     24,    0, 0, 0,             0,  0, 2));
        vecs.push_back(mk(0, 0, 0, 0,     28,    1, 1, 32'hA000_0018, 28, 0, 3));
        vecs.push_back(mk(0, 0, 0, 0,     32,    1, 1, 32'hA000_001C, 32, 0, 4));
        vecs.push_back(mk(0, 0, 0, 0,     36,    1, 1, 32'hA000_0020, 36, 0, 5));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(0, 1, 0, 0, 36,    1, 1, 32'hA000_0020, 36, 0, 5));
        vecs.push_back(mk(0, 0, 0, 0,     40,    1, 1, 32'hA000_0024, 40, 0, 6));
        vecs.push_back(mk(0, 0, 0, 0,     44,    1, 1, 32'hA000_0028, 44, 0, 7));
        vecs.push_back(mk(0, 0, 0, 0,     48,    1, 1, 32'hA000_002C, 48, 0, 8));
        vecs.push_back(mk(0, 0, 0, 0,     52,    1, 1, 32'hA000_0030, 52, 0, 9));
        vecs.push_back(mk(0, 0, 1, 40,    40,    0, 0, 0,             0,  0, 9));
        vecs.push_back(mk(0, 0, 0, 0,     44,    1, 1, 32'hA000_0028, 44, 0, 10));
        vecs.push_back(mk(0, 0, 0, 0,     48,    1, 1, 32'hA000_002C, 48, 0, 11));
        vecs.push_back(mk(0, 0, 0, 0,     52,    1, 1, 32'hA000_0030, 52, 0, 12));
        vecs.push_back(mk(1, 0, 0, 0,     0,     0, 1, 32'h0,         0,  0, 0));
        vecs.push_back(mk(0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,     0,     1, 1, 32'hA000_03FC, 0,  0, 1));

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], i);

        // Halt, hold for 10 cycles (one under stall), then resume via branch.
        apply(mk(0, 0, 1, 84, 84, 0, 0, 0, 0, 0, 1), 100);
        apply(mk(0, 0, 0, 0, 84, 1, 1, 32'h0000_0021, 88, 1, 2), 101);
        for (int k = 0; k < 10; k++)
            apply(mk(0, (k == 5), 0, 0, 84, 0, 1, 32'h0000_0021, 88, 1, 2), 110 + k);
        apply(mk(0, 0, 1, 68, 68, 0, 0, 0, 0, 0, 2), 120);
        apply(mk(0, 0, 0, 0, 72, 1, 1, 32'hA000_0044, 72, 0, 3), 121);

        // Reset while halted and stalled returns to RESET_PC and resumes.
        apply(mk(0, 0, 1, 84, 84, 0, 0, 0, 0, 0, 3), 130);
        apply(mk(0, 0, 0, 0, 84, 1, 1, 32'h0000_0021, 88, 1, 4), 131);
        apply(mk(1, 1, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0), 132);
        apply(mk(0, 0, 0, 0, 4, 1, 1, 32'hA000_0000, 4, 0, 1), 133);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
